// File: rtl/crc_frame_pkg.sv
// Shared definitions for the CRC framed byte receiver.
// State encoding and CRC8 constants.
package crc_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h8E;
    localparam logic [7:0] CRC8_INIT = 8'h00;

endpackage

// File: rtl/crc_8bit.sv
// Combinational CRC8 of one byte.
// MSB-first: conditional poly XOR, then shift left.
module crc_8bit
    import crc_frame_pkg::*;
(
    input  logic [7:0] i_data,
    output logic [7:0] o_crc
);

    logic [7:0] w_x;

    // Eight rounds of XOR-then-shift
    always_comb begin
        w_x = i_data;
        for (int i = 0; i < 8; i++) begin
            if (w_x[7]) begin
                w_x = w_x ^ CRC8_POLY;
            end
            w_x = {w_x[6:0], 1'b0};
        end
    end

    assign o_crc = w_x;

endmodule

// File: rtl/crc_frame_ctrl.sv
// LEN/payload/CRC frame receiver with payload pass-through.
// Optional idle abort: define CRC_FRAME_TIMEOUT_EN.
module crc_frame_ctrl #(
    parameter int MAX_LEN = 64,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_done,
    output logic       frame_ok,
    output logic       err_len,
    output logic       err_timeout
);
    import crc_frame_pkg::*;

    state_t     r_state;
    state_t     w_state_nx;
    logic [7:0] r_rem;
    logic [7:0] w_rem_nx;
    logic [7:0] r_crc;
    logic [7:0] w_crc_nx;
    logic       r_done;
    logic       w_done_nx;
    logic       r_ok;
    logic       w_ok_nx;
    logic       r_len;
    logic       w_len_nx;
    logic       w_s_ready;
    logic       w_m_valid;
    logic [7:0] w_crc_in;
    logic [7:0] w_crc_out;

`ifdef CRC_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST =
        TW'(TIMEOUT - 1);

    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_cnt_nx;
    logic          r_to;
    logic          w_to_nx;
`endif

    assign w_crc_in = r_crc ^ s_data;

    crc_8bit u_crc (
        .i_data (w_crc_in),
        .o_crc  (w_crc_out)
    );

    // Next-state, datapath updates and handshakes
    always_comb begin
        w_state_nx = r_state;
        w_rem_nx   = r_rem;
        w_crc_nx   = r_crc;
        w_done_nx  = 1'b0;
        w_ok_nx    = 1'b0;
        w_len_nx   = 1'b0;
        w_s_ready  = 1'b0;
        w_m_valid  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_s_ready = 1'b1;
                if (s_valid) begin
                    if (s_data == 8'h00 ||
                        s_data > 8'(MAX_LEN)) begin
                        w_len_nx = 1'b1;
                    end else begin
                        w_state_nx = ST_PAYLOAD;
                        w_rem_nx   = s_data;
                        w_crc_nx   = CRC8_INIT;
                    end
                end
            end
            ST_PAYLOAD: begin
                w_s_ready = m_ready;
                w_m_valid = s_valid;
                if (s_valid && m_ready) begin
                    w_crc_nx = w_crc_out;
                    w_rem_nx = r_rem - 8'd1;
                    if (r_rem == 8'd1) begin
                        w_state_nx = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                w_s_ready = 1'b1;
                if (s_valid) begin
                    w_state_nx = ST_IDLE;
                    w_done_nx  = 1'b1;
                    w_ok_nx    = (s_data == r_crc);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
`ifdef CRC_FRAME_TIMEOUT_EN
        w_cnt_nx = r_cnt;
        w_to_nx  = 1'b0;
        if (r_state == ST_IDLE) begin
            w_cnt_nx = '0;
        end else if (s_valid && w_s_ready) begin
            w_cnt_nx = '0;
        end else if (!s_valid) begin
            if (r_cnt == TO_LAST) begin
                w_cnt_nx   = '0;
                w_to_nx    = 1'b1;
                w_state_nx = ST_IDLE;
            end else begin
                w_cnt_nx = r_cnt + 1'b1;
            end
        end
`endif
    end

    // State, datapath and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rem   <= 8'd0;
            r_crc   <= CRC8_INIT;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
            r_len   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_rem   <= w_rem_nx;
            r_crc   <= w_crc_nx;
            r_done  <= w_done_nx;
            r_ok    <= w_ok_nx;
            r_len   <= w_len_nx;
        end
    end

`ifdef CRC_FRAME_TIMEOUT_EN
    // Inter-byte idle counter and abort pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_to  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nx;
            r_to  <= w_to_nx;
        end
    end

    assign err_timeout = r_to;
`else
    logic w_unused_to;
    assign w_unused_to = (TIMEOUT != 0);
    assign err_timeout = 1'b0;
`endif

    assign s_ready    = w_s_ready & rst_n;
    assign m_valid    = w_m_valid & rst_n;
    assign m_data     = s_data;
    assign frame_done = r_done;
    assign frame_ok   = r_ok;
    assign err_len    = r_len;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Scoreboard bench for crc_frame_ctrl.
// Table frames plus hand-written corner sequences.
module tb_crc_frame_ctrl;

    localparam int MAX_LEN = 64;
    localparam int TIMEOUT = 4;
    localparam int EV_OK  = 0;
    localparam int EV_BAD = 1;
    localparam int EV_LEN = 2;
    localparam int EV_TO  = 3;

    typedef struct {
        logic [7:0]      len;
        logic [3:0][7:0] pay;
        bit              expl;
        logic [7:0]      crc;
        bit              corrupt;
        bit              ramp;
        int              stall_at;
        int              exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic       frame_done;
    logic       frame_ok;
    logic       err_len;
    logic       err_timeout;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_m[$];
    int         exp_ev[$];
    vec_t       vecs[10];

    always #5 clk = ~clk;

    crc_frame_ctrl #(
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .err_len     (err_len),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h",
                     nm, act, exp);
        end
    endtask

    task automatic ev_check(input int got);
        int e;
        if (exp_ev.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL event_unexpected: got %0d, required none",
                     got);
        end else begin
            e = exp_ev.pop_front();
            chk("event", got, e);
        end
    endtask

    // Output monitor: mid-cycle, well before the next rising edge
    always @(negedge clk) begin
        #3;
        if (m_valid) begin
            if (exp_m.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL m_unexpected: got m_valid data %02h, required m_valid=0",
                         m_data);
            end else if (m_ready) begin
                chk("m_data", m_data, exp_m.pop_front());
            end
        end
        if (frame_done) ev_check(frame_ok ? EV_OK : EV_BAD);
        if (err_len) ev_check(EV_LEN);
        if (err_timeout) ev_check(EV_TO);
    end

    function automatic logic [7:0] crc8_m(input logic [7:0] x);
        logic [7:0] v;
        v = x;
        for (int i = 0; i < 8; i++) begin
            if (v[7]) v = v ^ 8'h8E;
            v = v << 1;
        end
        return v;
    endfunction

    function automatic vec_t mk(
        input logic [7:0] len,
        input logic [7:0] p0, p1, p2, p3,
        input bit expl, input logic [7:0] crc,
        input bit corrupt, input bit ramp,
        input int stall_at, input int exp);
        vec_t v;
        v.len = len;
        v.pay[0] = p0;
        v.pay[1] = p1;
        v.pay[2] = p2;
        v.pay[3] = p3;
        v.expl = expl;
        v.crc = crc;
        v.corrupt = corrupt;
        v.ramp = ramp;
        v.stall_at = stall_at;
        v.exp = exp;
        return v;
    endfunction

    // Called just after a falling edge; returns after acceptance
    task automatic send_byte(input logic [7:0] b);
        int n;
        logic rdy;
        n = 0;
        s_data = b;
        s_valid = 1'b1;
        while (1) begin
            #1;
            rdy = s_ready;
            @(negedge clk);
            if (rdy) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL s_accept: byte %02h not taken in 100 cycles, required acceptance",
                         b);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic stall(input logic [7:0] b);
        s_data = b;
        s_valid = 1'b1;
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_s_ready", s_ready, 1'b0);
            chk("stall_m_valid", m_valid, 1'b1);
            @(negedge clk);
        end
        m_ready = 1'b1;
    endtask

    task automatic send_frame(input vec_t v);
        logic [7:0] c;
        logic [7:0] b;
        c = 8'h00;
        if (v.exp == EV_LEN) begin
            exp_ev.push_back(v.exp);
            send_byte(v.len);
        end else begin
            send_byte(v.len);
            for (int i = 0; i < int'(v.len); i++) begin
                b = v.ramp ? 8'(i * 7 + 3) : v.pay[i % 4];
                c = crc8_m(c ^ b);
                exp_m.push_back(b);
                if (v.stall_at == i) stall(b);
                send_byte(b);
            end
            if (v.expl) c = v.crc;
            if (v.corrupt) c = c ^ 8'h5A;
            exp_ev.push_back(v.exp);
            send_byte(c);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation hung, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = mk(8'd1, 8'h01, 0, 0, 0, 1, 8'h1C, 0, 0, -1, EV_OK);
        vecs[1] = mk(8'd1, 8'h01, 0, 0, 0, 1, 8'h1D, 0, 0, -1, EV_BAD);
        vecs[2] = mk(8'd0, 0, 0, 0, 0, 0, 0, 0, 0, -1, EV_LEN);
        vecs[3] = mk(8'(MAX_LEN + 1), 0, 0, 0, 0, 0, 0, 0, 0, -1, EV_LEN);
        vecs[4] = mk(8'd1, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, -1, EV_OK);
        vecs[5] = mk(8'd2, 8'h01, 8'h00, 0, 0, 1, 8'h4C, 0, 0, 1, EV_OK);
        vecs[6] = mk(8'd4, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 0, 0, 0, 0, -1, EV_OK);
        vecs[7] = mk(8'd3, 8'hFF, 8'h80, 8'h7F, 0, 0, 0, 1, 0, -1, EV_BAD);
        vecs[8] = mk(8'(MAX_LEN), 0, 0, 0, 0, 0, 0, 0, 1, -1, EV_OK);
        vecs[9] = mk(8'd255, 0, 0, 0, 0, 0, 0, 0, 0, -1, EV_LEN);

        #2;
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_frame_ok", frame_ok, 1'b0);
        chk("rst_err_len", err_len, 1'b0);
        chk("rst_err_timeout", err_timeout, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_s_ready", s_ready, 1'b1);
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i]);
        end

        send_byte(8'h01);
        exp_m.push_back(8'h01);
        send_byte(8'h01);
        exp_ev.push_back(EV_OK);
        send_byte(8'h1C);
        s_data = 8'h01;
        s_valid = 1'b1;
        #1;
        chk("b2b_frame_done", frame_done, 1'b1);
        chk("b2b_s_ready", s_ready, 1'b1);
        send_byte(8'h01);
        exp_m.push_back(8'h00);
        send_byte(8'h00);
        exp_ev.push_back(EV_OK);
        send_byte(8'h00);

        send_byte(8'h02);
        exp_m.push_back(8'h01);
        send_byte(8'h01);
        rst_n = 1'b0;
        #1;
        chk("midrst_s_ready", s_ready, 1'b0);
        chk("midrst_m_valid", m_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(vecs[6]);

`ifdef CRC_FRAME_TIMEOUT_EN
        send_byte(8'h02);
        exp_m.push_back(8'h01);
        send_byte(8'h01);
        exp_ev.push_back(EV_TO);
        repeat (8) @(negedge clk);
        send_frame(vecs[0]);
`endif

        n = 0;
        while ((exp_m.size() != 0 || exp_ev.size() != 0)
               && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("m_queue_drained", exp_m.size(), 0);
        chk("ev_queue_drained", exp_ev.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
